// File: rtl/shift_seq_pkg.sv
// Shared op codes, FSM states and shift-op decode for the shift_sequencer family.
package shift_seq_pkg;

  localparam logic [2:0] OPC_NOP   = 3'b000;
  localparam logic [2:0] OPC_LOAD  = 3'b001;
  localparam logic [2:0] OPC_SHL   = 3'b010;
  localparam logic [2:0] OPC_SHR   = 3'b011;
  localparam logic [2:0] OPC_ROL   = 3'b100;
  localparam logic [2:0] OPC_ROR   = 3'b101;
  localparam logic [2:0] OPC_ASR   = 3'b110;
  localparam logic [2:0] OPC_CLEAR = 3'b111;

  typedef enum logic [2:0] {
    OP_NOP   = OPC_NOP,
    OP_LOAD  = OPC_LOAD,
    OP_SHL   = OPC_SHL,
    OP_SHR   = OPC_SHR,
    OP_ROL   = OPC_ROL,
    OP_ROR   = OPC_ROR,
    OP_ASR   = OPC_ASR,
    OP_CLEAR = OPC_CLEAR
  } op_e;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_RUN  = 2'd1,
    ST_DONE = 2'd2
  } state_e;

  // Direction and fill source of a shift/rotate op; shared by serial and barrel paths.
  typedef struct packed {
    logic left;
    logic rotate;
    logic arith;
  } shift_dec_t;

  function automatic logic is_shift_op(input op_e op);
    return (op != OP_NOP) && (op != OP_LOAD) && (op != OP_CLEAR);
  endfunction

  function automatic shift_dec_t decode_op(input op_e op);
    shift_dec_t d;
    d = '0;
    case (op)
      OP_SHL:  d.left = 1'b1;
      OP_ROL:  begin d.left = 1'b1; d.rotate = 1'b1; end
      OP_ROR:  d.rotate = 1'b1;
      OP_ASR:  d.arith = 1'b1;
      default: d = '0;
    endcase
    return d;
  endfunction

endpackage

// File: rtl/shift_seq_step.sv
// Combinational single-bit shift/rotate step: next register value and carry-out.
module shift_seq_step
  import shift_seq_pkg::*;
#(
  parameter int WIDTH = 16
) (
  input  logic [WIDTH-1:0] i_r,
  input  op_e              i_op,
  input  logic             i_fill_left,
  input  logic             i_fill_right,
  output logic [WIDTH-1:0] o_r,
  output logic             o_carry
);

  shift_dec_t w_dec;
  logic       w_msb_in;

  assign w_dec    = decode_op(i_op);
  assign w_msb_in = w_dec.rotate ? i_r[0] : (w_dec.arith ? i_r[WIDTH-1] : i_fill_left);

  always_comb begin
    o_r     = i_r;
    o_carry = 1'b0;
    if (is_shift_op(i_op)) begin
      if (w_dec.left) begin
        o_r     = {i_r[WIDTH-2:0], (w_dec.rotate ? i_r[WIDTH-1] : i_fill_right)};
        o_carry = i_r[WIDTH-1];
      end else begin
        o_r     = {w_msb_in, i_r[WIDTH-1:1]};
        o_carry = i_r[0];
      end
    end
  end

endmodule

// File: rtl/shift_sequencer.sv
// Universal shift register with start/busy/done handshake.
// Define SHIFT_SEQ_BARREL_EN to complete shifts in one cycle via a barrel shifter.
module shift_sequencer
  import shift_seq_pkg::*;
#(
  parameter int WIDTH = 16,
  parameter int AMT_W = 5
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [WIDTH-1:0] a,
  input  logic             I_left,
  input  logic             I_right,
  input  logic [2:0]       op,
  input  logic [AMT_W-1:0] amount,
  input  logic             start,
  output logic [WIDTH-1:0] R,
  output logic             carry,
  output logic             busy,
  output logic             done
);

  state_e           r_state, w_state_next;
  logic [WIDTH-1:0] r_data,  w_data_next;
  logic             r_carry, w_carry_next;
  op_e              w_op;

  assign w_op  = op_e'(op);
  assign R     = r_data;
  assign carry = r_carry;
  assign busy  = (r_state == ST_RUN);
  assign done  = (r_state == ST_DONE);

`ifdef SHIFT_SEQ_BARREL_EN
  localparam int EXT_W = 2 * WIDTH + 2;

  shift_dec_t         w_dec;
  logic               w_fill;
  int                 w_rot_k;
  int                 w_sh_n;
  logic [2*WIDTH-1:0] w_rot;
  logic [EXT_W-1:0]   w_ext;
  logic [WIDTH-1:0]   w_bar_data;
  logic               w_bar_carry;

  assign w_dec = decode_op(w_op);

  // Shifts past WIDTH+1 only keep refilling, so the amount saturates there;
  // the extra bit above/below R in w_ext becomes the last bit shifted out.
  always_comb begin
    w_fill      = w_dec.left ? I_right : (w_dec.arith ? r_data[WIDTH-1] : I_left);
    w_rot_k     = int'(amount) % WIDTH;
    w_sh_n      = (int'(amount) > WIDTH + 1) ? WIDTH + 1 : int'(amount);
    w_rot       = '0;
    w_ext       = '0;
    w_bar_data  = r_data;
    w_bar_carry = r_carry;
    if (w_dec.rotate) begin
      if (w_dec.left) begin
        w_rot      = {r_data, r_data} << w_rot_k;
        w_bar_data = w_rot[2*WIDTH-1:WIDTH];
      end else begin
        w_rot      = {r_data, r_data} >> w_rot_k;
        w_bar_data = w_rot[WIDTH-1:0];
      end
      if (amount != '0) w_bar_carry = w_dec.left ? w_bar_data[0] : w_bar_data[WIDTH-1];
    end else if (w_dec.left) begin
      w_ext       = {r_carry, r_data, {(WIDTH+1){w_fill}}} << w_sh_n;
      w_bar_data  = w_ext[2*WIDTH:WIDTH+1];
      w_bar_carry = w_ext[EXT_W-1];
    end else begin
      w_ext       = {{(WIDTH+1){w_fill}}, r_data, r_carry} >> w_sh_n;
      w_bar_data  = w_ext[WIDTH:1];
      w_bar_carry = w_ext[0];
    end
  end
`else
  op_e              r_op,  w_op_next;
  logic [AMT_W-1:0] r_cnt, w_cnt_next;
  logic [WIDTH-1:0] w_step_data;
  logic             w_step_carry;

  shift_seq_step #(.WIDTH(WIDTH)) u_step (
    .i_r          (r_data),
    .i_op         (r_op),
    .i_fill_left  (I_left),
    .i_fill_right (I_right),
    .o_r          (w_step_data),
    .o_carry      (w_step_carry)
  );
`endif

  always_comb begin
    // NOTE: every signal gets a default first so no path can infer a latch.
    w_state_next = r_state;
    w_data_next  = r_data;
    w_carry_next = r_carry;
`ifndef SHIFT_SEQ_BARREL_EN
    w_op_next    = r_op;
    w_cnt_next   = r_cnt;
`endif
    case (r_state)
      ST_RUN: begin
`ifdef SHIFT_SEQ_BARREL_EN
        w_state_next = ST_IDLE;
`else
        w_data_next  = w_step_data;
        w_carry_next = w_step_carry;
        w_cnt_next   = r_cnt - 1'b1;
        if (r_cnt == AMT_W'(1)) w_state_next = ST_DONE;
`endif
      end
      default: begin
        w_state_next = ST_IDLE;
        if (start) begin
          w_state_next = ST_DONE;
          if (is_shift_op(w_op)) begin
`ifdef SHIFT_SEQ_BARREL_EN
            w_data_next  = w_bar_data;
            w_carry_next = w_bar_carry;
`else
            w_op_next  = w_op;
            w_cnt_next = amount;
            if (amount != '0) w_state_next = ST_RUN;
`endif
          end else if (w_op == OP_LOAD) begin
            w_data_next = a;
          end else if (w_op == OP_CLEAR) begin
            w_data_next  = '0;
            w_carry_next = 1'b0;
          end
        end
      end
    endcase
  end

  always_ff @(posedge clk) begin
    // NOTE: non-blocking assignments so every flop samples pre-edge values.
    if (rst) begin
      r_state <= ST_IDLE;
      r_data  <= '0;
      r_carry <= 1'b0;
`ifndef SHIFT_SEQ_BARREL_EN
      r_op    <= OP_NOP;
      r_cnt   <= '0;
`endif
    end else begin
      r_state <= w_state_next;
      r_data  <= w_data_next;
      r_carry <= w_carry_next;
`ifndef SHIFT_SEQ_BARREL_EN
      r_op    <= w_op_next;
      r_cnt   <= w_cnt_next;
`endif
    end
  end

endmodule

// File: tb/tb_shift_sequencer.sv
// Self-checking bench for shift_sequencer: per-cycle model compare plus literal results.
module tb_shift_sequencer;

`ifdef SHIFT_SEQ_BARREL_EN
  localparam bit BARREL = 1'b1;
`else
  localparam bit BARREL = 1'b0;
`endif

  logic        clk = 1'b0;
  logic        rst;
  logic [15:0] a;
  logic        I_left, I_right;
  logic [2:0]  op;
  logic [4:0]  amount;
  logic        start;
  logic [15:0] R;
  logic        carry, busy, done;

  int n_checks = 0;
  int n_errors = 0;
  bit cmp_en   = 1'b0;

  shift_sequencer #(.WIDTH(16), .AMT_W(5)) dut (
    .clk     (clk),
    .rst     (rst),
    .a       (a),
    .I_left  (I_left),
    .I_right (I_right),
    .op      (op),
    .amount  (amount),
    .start   (start),
    .R       (R),
    .carry   (carry),
    .busy    (busy),
    .done    (done)
  );

  always #5 clk = ~clk;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // Final {carry, R} after n single-bit steps with constant fill.
  function automatic logic [16:0] mdl_shift(input logic [2:0] o, input logic [15:0] r,
                                            input logic c, input int n,
                                            input logic fl, input logic fr);
    for (int i = 0; i < n; i++) begin
      case (o)
        3'b010: begin c = r[15]; r = (r << 1) | 16'(fr); end
        3'b011: begin c = r[0];  r = (r >> 1) | (16'(fl) << 15); end
        3'b100: begin c = r[15]; r = (r << 1) | (r >> 15); end
        3'b101: begin c = r[0];  r = (r >> 1) | (r << 15); end
        default: begin c = r[0]; r = (r >> 1) | (r & 16'h8000); end
      endcase
    end
    return {c, r};
  endfunction

  function automatic int lat(input int n);
    return (BARREL || n == 0) ? 1 : n + 1;
  endfunction

  logic [15:0] m_R = '0, m_pR = '0;
  logic        m_c = 1'b0, m_pC = 1'b0, m_done = 1'b0;
  int          m_left = 0;

  always @(posedge clk) begin
    if (rst) begin
      m_R <= '0; m_c <= 1'b0; m_left <= 0; m_done <= 1'b0;
    end else if (m_left > 0) begin
      m_left <= m_left - 1;
      m_done <= (m_left == 1);
      if (m_left == 1) begin
        m_R <= m_pR;
        m_c <= m_pC;
      end
    end else begin
      m_done <= start;
      if (start) begin
        case (op)
          3'b000: ;
          3'b001: m_R <= a;
          3'b111: begin m_R <= '0; m_c <= 1'b0; end
          default: begin
            if (BARREL || amount == 0) begin
              {m_c, m_R} <= mdl_shift(op, m_R, m_c, int'(amount), I_left, I_right);
            end else begin
              {m_pC, m_pR} <= mdl_shift(op, m_R, m_c, int'(amount), I_left, I_right);
              m_left <= int'(amount);
              m_done <= 1'b0;
            end
          end
        endcase
      end
    end
  end

  always @(negedge clk) begin
    if (cmp_en) begin
      check("busy", busy, m_left > 0);
      check("done", done, m_done);
      check("busy_done_excl", busy & done, 1'b0);
      if (m_left == 0) begin
        check("R", R, m_R);
        check("carry", carry, m_c);
      end
    end
  end

  task automatic issue(input logic [2:0] o, input logic [4:0] n, input logic [15:0] d,
                       input logic fl, input logic fr);
    @(posedge clk); #1;
    op = o; amount = n; a = d; I_left = fl; I_right = fr; start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
  endtask

  task automatic wait_done(input string nm, input int exp_lat);
    int k;
    k = 0;
    for (int i = 1; i <= 200; i++) begin
      @(negedge clk);
      if (done) begin
        k = i;
        break;
      end
    end
    check(nm, k, exp_lat);
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not complete");
    $fatal(1, "watchdog");
  end

  initial begin
    int dn;
    rst = 1'b1; start = 1'b1; op = 3'b010; amount = 5'd7; a = 16'hDEAD;
    I_left = 1'b1; I_right = 1'b1;
    repeat (2) @(posedge clk);
    #1 rst = 1'b0; start = 1'b0; cmp_en = 1'b1;
    @(negedge clk);
    check("rst_R", R, 16'h0000);
    check("rst_carry", carry, 1'b0);
    check("rst_busy", busy, 1'b0);
    check("rst_done", done, 1'b0);

    issue(3'b001, 5'd0, 16'hA5C3, 1'b0, 1'b0);
    wait_done("load_lat", 1);
    check("load_R", R, 16'hA5C3);
    @(negedge clk);
    check("load_done_1cyc", done, 1'b0);

    issue(3'b010, 5'd4, 16'h0000, 1'b0, 1'b1);
    wait_done("shl4_lat", lat(4));
    check("shl4_R", R, 16'h5C3F);
    check("shl4_carry", carry, 1'b0);

    issue(3'b001, 5'd0, 16'h8001, 1'b0, 1'b0);
    wait_done("load2_lat", 1);
    issue(3'b101, 5'd20, 16'h0000, 1'b0, 1'b0);
    wait_done("ror20_lat", lat(20));
    check("ror20_R", R, 16'h1800);
    check("ror20_carry", carry, 1'b0);

    issue(3'b001, 5'd0, 16'h8000, 1'b0, 1'b0);
    wait_done("load3_lat", 1);
    issue(3'b110, 5'd3, 16'h0000, 1'b1, 1'b1);
    wait_done("asr3_lat", lat(3));
    check("asr3_R", R, 16'hF000);
    check("asr3_carry", carry, 1'b0);

    issue(3'b010, 5'd0, 16'hFFFF, 1'b1, 1'b1);
    wait_done("shl0_lat", 1);
    check("shl0_R", R, 16'hF000);
    // back-to-back: start presented during the DONE cycle
    op = 3'b001; a = 16'h1234; start = 1'b1;
    @(posedge clk); #1 start = 1'b0;
    @(negedge clk);
    check("b2b_done", done, 1'b1);
    check("b2b_R", R, 16'h1234);

`ifndef SHIFT_SEQ_BARREL_EN
    issue(3'b001, 5'd0, 16'hA5C3, 1'b0, 1'b0);
    wait_done("load4_lat", 1);
    issue(3'b011, 5'd8, 16'h0000, 1'b0, 1'b0);
    @(posedge clk); #1 op = 3'b001; a = 16'hFFFF; start = 1'b1;
    @(posedge clk); #1 start = 1'b0;
    wait_done("shr8_ign_lat", 7);
    check("shr8_R", R, 16'h00A5);
    check("shr8_carry", carry, 1'b1);
`endif

    issue(3'b011, 5'd8, 16'h0000, 1'b0, 1'b0);
    @(posedge clk); @(posedge clk); #1 rst = 1'b1;
    @(posedge clk); #1 rst = 1'b0;
    @(negedge clk);
    check("abort_R", R, 16'h0000);
    check("abort_busy", busy, 1'b0);
    dn = 0;
    repeat (12) begin
      @(negedge clk);
      if (done) dn++;
    end
    check("abort_no_done", dn, 0);

    issue(3'b001, 5'd0, 16'hFFFF, 1'b0, 1'b0);
    wait_done("load5_lat", 1);
    issue(3'b010, 5'd1, 16'h0000, 1'b0, 1'b0);
    wait_done("shl1_lat", lat(1));
    check("shl1_R", R, 16'hFFFE);
    check("shl1_carry", carry, 1'b1);
    issue(3'b111, 5'd0, 16'h0000, 1'b0, 1'b0);
    wait_done("clear_lat", 1);
    check("clear_R", R, 16'h0000);
    check("clear_carry", carry, 1'b0);

    issue(3'b011, 5'd31, 16'h0000, 1'b1, 1'b0);
    wait_done("shr31_lat", lat(31));
    check("shr31_R", R, 16'hFFFF);
    check("shr31_carry", carry, 1'b1);

    issue(3'b001, 5'd0, 16'h8001, 1'b0, 1'b0);
    wait_done("load6_lat", 1);
    issue(3'b100, 5'd16, 16'h0000, 1'b0, 1'b0);
    wait_done("rol16_lat", lat(16));
    check("rol16_R", R, 16'h8001);
    check("rol16_carry", carry, 1'b1);

    repeat (2) @(negedge clk);
    cmp_en = 1'b0;
    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
